// File: rtl/asic_iopoc_pkg.sv
// asic_iopoc_pkg -- shared types for the padring power-on-control sequencer.
//   STATE_W : width of the sequencer state encoding
//   state_t : sequencer states
package asic_iopoc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RAMP   = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_DOWN   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

endpackage

// File: rtl/asic_iopoc_sync.sv
// asic_iopoc_sync -- two-flop synchronizer, active-low asynchronous reset to 0.
// Ports:
//   clk    : destination clock
//   nreset : asynchronous active-low reset
//   d      : asynchronous inputs (WIDTH bits)
//   q      : synchronized outputs (WIDTH bits)
module asic_iopoc_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/asic_iopoc_seq.sv
// asic_iopoc_seq -- padring power-on-control sequencer.
// Holds every IO safe (poc=1) until core and IO supplies are good, then
// releases poc and enables the IO banks one at a time, SETTLE cycles apart.
// Collapses back to the safe state on shutdown (banks cleared top-down) or
// immediately on supply loss (sticky fault until en is dropped).
//
// Build option: define ASIC_IOPOC_SYNC_EN to pass en, vdd_ok and vddio_ok
// through two-flop synchronizers (adds 2 cycles to every input response).
//
// Ports:
//   clk      : sequencer clock
//   nreset   : asynchronous active-low reset
//   en       : power-up request, low requests shutdown
//   vdd_ok   : core supply good
//   vddio_ok : IO supply good
//   poc      : power-on-control to padring, 1 = IOs held safe
//   bank_en  : per-bank IO enable, thermometer coded from bit 0
//   ready    : all banks enabled
//   fault    : supply lost while sequencing or active (sticky)
//
// state  | meaning
// OFF    | idle, IOs safe, waiting for en
// WAIT   | en seen, waiting for both supplies good
// SETTLE | supplies good, waiting SETTLE cycles before releasing poc
// RAMP   | poc released, enabling one more bank every SETTLE cycles
// ACTIVE | all banks enabled, ready high
// DOWN   | shutting down, clearing highest enabled bank each cycle
// FAULT  | supply lost, everything safe until en drops
module asic_iopoc_seq #(
  parameter int NBANKS = 4,
  parameter int SETTLE = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  input  logic              vdd_ok,
  input  logic              vddio_ok,
  output logic              poc,
  output logic [NBANKS-1:0] bank_en,
  output logic              ready,
  output logic              fault
);

  import asic_iopoc_pkg::*;

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBANKS - 1);

  logic en_s;
  logic vdd_s;
  logic vddio_s;
  logic sup_ok;

`ifdef ASIC_IOPOC_SYNC_EN
  asic_iopoc_sync #(.WIDTH(3)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      ({en, vdd_ok, vddio_ok}),
    .q      ({en_s, vdd_s, vddio_s})
  );
`else
  assign en_s    = en;
  assign vdd_s   = vdd_ok;
  assign vddio_s = vddio_ok;
`endif

  assign sup_ok = vdd_s & vddio_s;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            powered;

  // Supply loss only matters once the sequence has started.
  assign powered = (state == ST_SETTLE) || (state == ST_RAMP) ||
                   (state == ST_ACTIVE) || (state == ST_DOWN);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_OFF;
      cnt     <= '0;
      idx     <= '0;
      poc     <= 1'b1;
      bank_en <= '0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else if (powered && !sup_ok) begin
      // Supply loss outranks a simultaneous shutdown request.
      state   <= ST_FAULT;
      cnt     <= '0;
      idx     <= '0;
      poc     <= 1'b1;
      bank_en <= '0;
      ready   <= 1'b0;
      fault   <= 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (en_s) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!en_s) begin
            state <= ST_OFF;
          end else if (sup_ok) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (!en_s) begin
            state <= ST_DOWN;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_RAMP;
            cnt     <= '0;
            idx     <= '0;
            poc     <= 1'b0;
            bank_en <= NBANKS'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RAMP: begin
          if (!en_s) begin
            state <= ST_DOWN;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_ACTIVE;
              ready <= 1'b1;
            end else begin
              idx     <= idx + 1'b1;
              bank_en <= (bank_en << 1) | NBANKS'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!en_s) begin
            state <= ST_DOWN;
            ready <= 1'b0;
          end
        end
        ST_DOWN: begin
          // Thermometer code: shifting right drops the highest set bank.
          bank_en <= bank_en >> 1;
          if ((bank_en >> 1) == '0) begin
            state <= ST_OFF;
            poc   <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        ST_FAULT: begin
          if (!en_s) begin
            state <= ST_OFF;
            fault <= 1'b0;
          end
        end
        default: begin
          state <= ST_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// tb_asic_iopoc_seq -- self-checking bench for asic_iopoc_seq (NBANKS=4,
// SETTLE=16). Expected outputs come from an edge-number timing model:
// after the edge s at which supplies are first seen good in WAIT, the
// number of completed settle periods k=(n-s)/SETTLE fixes poc, bank_en
// and ready; shutdown and fault are modelled the same way from the edge
// at which the request is seen.
module tb_asic_iopoc_seq;

  localparam int NB = 4;
  localparam int ST = 16;
`ifdef ASIC_IOPOC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic en = 1'b0;
  logic vdd_ok = 1'b0;
  logic vddio_ok = 1'b0;
  logic poc;
  logic [NB-1:0] bank_en;
  logic ready;
  logic fault;
  logic [NB+2:0] obs;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  localparam logic [NB+2:0] RST_V   = {1'b1, {NB{1'b0}}, 1'b0, 1'b0};
  localparam logic [NB+2:0] FAULT_V = {1'b1, {NB{1'b0}}, 1'b0, 1'b1};
  localparam logic [NB+2:0] ACT_V   = {1'b0, {NB{1'b1}}, 1'b1, 1'b0};

  always #5 clk = ~clk;

  assign obs = {poc, bank_en, ready, fault};

  asic_iopoc_seq #(.NBANKS(NB), .SETTLE(ST)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .en       (en),
    .vdd_ok   (vdd_ok),
    .vddio_ok (vddio_ok),
    .poc      (poc),
    .bank_en  (bank_en),
    .ready    (ready),
    .fault    (fault)
  );

  // ---------------- reference model ----------------
  function automatic logic [NB-1:0] therm(int k);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  // Power-up: s is the edge where supplies are first seen good in WAIT.
  function automatic logic [NB+2:0] exp_up(int n, int s);
    int k;
    int b;
    if (n < s) return RST_V;
    k = (n - s) / ST;
    b = (k > NB) ? NB : k;
    return {(k == 0), therm(b), (k > NB), 1'b0};
  endfunction

  // Shutdown: e is the edge where en is seen low, m the banks set before it.
  function automatic logic [NB+2:0] exp_down(int n, int e, int m);
    int b;
    b = m - (n - e);
    if (b < 0) b = 0;
    return {(b == 0), therm(b), 1'b0, 1'b0};
  endfunction

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    en = 1'b0;
    vdd_ok = 1'b0;
    vddio_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    edge_n = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    en = 1'b1;
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== RST_V) begin
      failures++;
      $display("FAIL reset_hold got=%b want=%b", obs, RST_V);
    end
    do_reset();
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    repeat (5) begin
      tick();
      checks++;
      if (obs !== RST_V) begin
        failures++;
        $display("FAIL reset_idle edge=%0d got=%b want=%b", edge_n, obs, RST_V);
      end
    end
  endtask

  task automatic test_powerup();
    int s;
    do_reset();
    en = 1'b1;
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    s = 2 + LAT;
    while (edge_n < s + ST * (NB + 1) + 4) begin
      tick();
      checks++;
      if (obs !== exp_up(edge_n, s)) begin
        failures++;
        $display("FAIL powerup edge=%0d got=%b want=%b", edge_n, obs, exp_up(edge_n, s));
      end
    end
  endtask

  // Runs from ACTIVE.
  task automatic test_shutdown();
    int hold = $urandom_range(0, 10);
    int e;
    logic [NB+2:0] want;
    repeat (hold) tick();
    en = 1'b0;
    e = edge_n + 1 + LAT;
    while (edge_n < e + NB + 3) begin
      tick();
      want = (edge_n < e) ? ACT_V : exp_down(edge_n, e, NB);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL shutdown edge=%0d got=%b want=%b", edge_n, obs, want);
      end
    end
  endtask

  task automatic test_supply_wait();
    int w = $urandom_range(80, 120);
    int s;
    do_reset();
    en = 1'b1;
    vdd_ok = 1'b1;
    vddio_ok = 1'b0;
    repeat (w) begin
      tick();
      checks++;
      if (obs !== RST_V) begin
        failures++;
        $display("FAIL supply_wait edge=%0d got=%b want=%b", edge_n, obs, RST_V);
      end
    end
    vddio_ok = 1'b1;
    s = edge_n + 1 + LAT;
    while (edge_n < s + ST * (NB + 1) + 2) begin
      tick();
      checks++;
      if (obs !== exp_up(edge_n, s)) begin
        failures++;
        $display("FAIL supply_wait_up edge=%0d got=%b want=%b", edge_n, obs, exp_up(edge_n, s));
      end
    end
  endtask

  // Runs from ACTIVE.
  task automatic test_fault_active();
    int f;
    int c;
    int r = $urandom_range(2, 8);
    logic [NB+2:0] want;
    vdd_ok = 1'b0;
    f = edge_n + 1 + LAT;
    while (edge_n < f + r) begin
      tick();
      want = (edge_n < f) ? ACT_V : FAULT_V;
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL fault_active edge=%0d got=%b want=%b", edge_n, obs, want);
      end
    end
    vdd_ok = 1'b1;
    repeat (r + LAT) begin
      tick();
      checks++;
      if (obs !== FAULT_V) begin
        failures++;
        $display("FAIL fault_sticky edge=%0d got=%b want=%b", edge_n, obs, FAULT_V);
      end
    end
    en = 1'b0;
    c = edge_n + 1 + LAT;
    while (edge_n < c + 3) begin
      tick();
      want = (edge_n < c) ? FAULT_V : RST_V;
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL fault_clear edge=%0d got=%b want=%b", edge_n, obs, want);
      end
    end
  endtask

  // en drops mid-RAMP; with_fault also drops vdd_ok in the same cycle.
  task automatic test_ramp_abort(input bit with_fault);
    int s;
    int e;
    int m;
    logic [NB+2:0] want;
    do_reset();
    en = 1'b1;
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    s = 2 + LAT;
    e = $urandom_range(s + ST + 1, s + ST * (NB + 1) - 1);
    m = (e - 1 - s) / ST;
    if (m > NB) m = NB;
    while (edge_n < e + NB + 3) begin
      if (edge_n == e - LAT - 1) begin
        en = 1'b0;
        if (with_fault) vdd_ok = 1'b0;
      end
      tick();
      if (edge_n < e) want = exp_up(edge_n, s);
      else if (with_fault) want = (edge_n == e) ? FAULT_V : RST_V;
      else want = exp_down(edge_n, e, m);
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL ramp_abort fault=%0d e=%0d edge=%0d got=%b want=%b",
                 with_fault, e, edge_n, obs, want);
      end
    end
  endtask

  task automatic test_async_reset();
    int s;
    int target;
    do_reset();
    en = 1'b1;
    vdd_ok = 1'b1;
    vddio_ok = 1'b1;
    s = 2 + LAT;
    target = $urandom_range(s + ST + 1, s + ST * NB);
    while (edge_n < target) tick();
    checks++;
    if (obs !== exp_up(edge_n, s)) begin
      failures++;
      $display("FAIL async_pre edge=%0d got=%b want=%b", edge_n, obs, exp_up(edge_n, s));
    end
    #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (obs !== RST_V) begin
      failures++;
      $display("FAIL async_reset edge=%0d got=%b want=%b", edge_n, obs, RST_V);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_shutdown();
    test_supply_wait();
    test_fault_active();
    repeat (3) test_ramp_abort(1'b0);
    repeat (3) test_ramp_abort(1'b1);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
